// File: rtl/ex_md_unit_pkg.sv
// ex_md_unit_pkg -- shared encodings for the execute stage.
//   ALU operation / result-class codes (ALUOP_*, ALUSEL_*), divider FSM
//   state encoding (DIV_IDLE/BUSY/DONE) and the stall tie-off value used
//   when the divider is compiled out (EX_DIV_EN undefined).
package ex_md_unit_pkg;

    localparam int ALUOP_W  = 8;
    localparam int ALUSEL_W = 3;

    typedef logic [ALUOP_W-1:0]  aluop_bus_t;
    typedef logic [ALUSEL_W-1:0] alusel_bus_t;

    localparam aluop_bus_t ALUOP_NOP   = 8'h00;
    localparam aluop_bus_t ALUOP_SRL   = 8'h02;
    localparam aluop_bus_t ALUOP_SRA   = 8'h03;
    localparam aluop_bus_t ALUOP_MULT  = 8'h18;
    localparam aluop_bus_t ALUOP_MULTU = 8'h19;
    localparam aluop_bus_t ALUOP_DIV   = 8'h1a;
    localparam aluop_bus_t ALUOP_DIVU  = 8'h1b;
    localparam aluop_bus_t ALUOP_ADD   = 8'h20;
    localparam aluop_bus_t ALUOP_ADDU  = 8'h21;
    localparam aluop_bus_t ALUOP_SUB   = 8'h22;
    localparam aluop_bus_t ALUOP_SUBU  = 8'h23;
    localparam aluop_bus_t ALUOP_AND   = 8'h24;
    localparam aluop_bus_t ALUOP_OR    = 8'h25;
    localparam aluop_bus_t ALUOP_XOR   = 8'h26;
    localparam aluop_bus_t ALUOP_NOR   = 8'h27;
    localparam aluop_bus_t ALUOP_SLT   = 8'h2a;
    localparam aluop_bus_t ALUOP_SLTU  = 8'h2b;
    localparam aluop_bus_t ALUOP_SLL   = 8'h7c;

    localparam alusel_bus_t ALUSEL_NOP   = 3'b000;
    localparam alusel_bus_t ALUSEL_LOGIC = 3'b001;
    localparam alusel_bus_t ALUSEL_SHIFT = 3'b010;
    localparam alusel_bus_t ALUSEL_ARITH = 3'b100;
    localparam alusel_bus_t ALUSEL_LINK  = 3'b110;
    localparam alusel_bus_t ALUSEL_HILO  = 3'b111;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam logic STALLREQ_DISABLE = 1'b0;

    function automatic logic is_div_op(input aluop_bus_t op);
        return (op == ALUOP_DIV) || (op == ALUOP_DIVU);
    endfunction

endpackage

// File: rtl/ex_md_unit_div.sv
// ex_div -- iterative restoring divider, one quotient bit per cycle.
//   Only present when EX_DIV_EN is defined.
//   clk/rst      : clock, async active-low reset
//   start        : a divide is presented this cycle
//   signed_op    : DIV (1) vs DIVU (0)
//   flush        : abort; forces IDLE and masks busy/done at once
//   hold         : downstream stall, keeps the result in DONE
//   dividend/divisor : operands, latched at issue
//   busy         : stall request (issue cycle and every BUSY cycle)
//   done         : result valid (HI/LO write strobe)
//   quotient/remainder : sign-corrected results, valid while done
`ifdef EX_DIV_EN
module ex_div
    import ex_md_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_op,
    input  logic              flush,
    input  logic              hold,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;   // dividend shifts out as quotient shifts in
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;

    logic              dvd_neg, dvs_neg;
    logic [DATA_W:0]   shifted, trial;

    assign dvd_neg = signed_op & dividend[DATA_W-1];
    assign dvs_neg = signed_op & divisor[DATA_W-1];
    assign shifted = {rem_q, quo_q[DATA_W-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        case (state_q)
            DIV_IDLE: begin
                if (start && !flush) begin
                    if (divisor == '0) begin
                        // Divide by zero skips the iterations entirely.
                        state_d   = DIV_DONE;
                        quo_d     = '1;
                        rem_d     = dividend;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                    end else begin
                        // Work on magnitudes; MIN_INT stays 1<<(W-1) unsigned,
                        // which makes MIN_INT / -1 come out as MIN_INT, rem 0.
                        state_d   = DIV_BUSY;
                        cnt_d     = CNT_W'(DATA_W);
                        rem_d     = '0;
                        quo_d     = dvd_neg ? -dividend : dividend;
                        dvs_d     = dvs_neg ? -divisor  : divisor;
                        neg_quo_d = dvd_neg ^ dvs_neg;
                        neg_rem_d = dvd_neg;
                    end
                end
            end
            DIV_BUSY: begin
                if (flush) begin
                    state_d = DIV_IDLE;
                end else begin
                    if (shifted >= {1'b0, dvs_q}) begin
                        rem_d = trial[DATA_W-1:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[DATA_W-1:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (flush || !hold) state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    // flush masks both strobes in the same cycle.
    assign busy      = !flush && (((state_q == DIV_IDLE) && start) || (state_q == DIV_BUSY));
    assign done      = !flush && (state_q == DIV_DONE);
    assign quotient  = neg_quo_q ? -quo_q : quo_q;
    assign remainder = neg_rem_q ? -rem_q : rem_q;

endmodule
`endif

// File: rtl/ex_md_unit.sv
// ex_md_unit -- EX stage: logic/shift/arith/link ALU paths, single-cycle
//   MULT/MULTU and (when EX_DIV_EN is defined) multi-cycle DIV/DIVU.
//   clk/rst          : clock, async active-low reset
//   flush_i/stall_i  : from ctrl
//   aluop_i/alusel_i : operation and result class
//   rdata1_i/rdata2_i: operands (rdata1 = shift amount / dividend)
//   waddr_i/we_i/laddr_i : destination, GPR write enable, link address
//   waddr_o/we_o/wdata_o : GPR write (we_o dropped on ADD/SUB overflow)
//   ovf_o            : signed overflow, to exception logic
//   hilo_we_o/hi_o/lo_o  : HI/LO write
//   stallreq_o       : divide in flight, to ctrl
// All outputs are forced to 0 while rst is low.
module ex_md_unit
    import ex_md_unit_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int IADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               stall_i,
    input  aluop_bus_t         aluop_i,
    input  alusel_bus_t        alusel_i,
    input  logic [DATA_W-1:0]  rdata1_i,
    input  logic [DATA_W-1:0]  rdata2_i,
    input  logic [RADDR_W-1:0] waddr_i,
    input  logic               we_i,
    input  logic [IADDR_W-1:0] laddr_i,
    output logic [RADDR_W-1:0] waddr_o,
    output logic               we_o,
    output logic [DATA_W-1:0]  wdata_o,
    output logic               ovf_o,
    output logic               hilo_we_o,
    output logic [DATA_W-1:0]  hi_o,
    output logic [DATA_W-1:0]  lo_o,
    output logic               stallreq_o
);
    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0]     shamt;
    logic [DATA_W-1:0]   logic_res, shift_res, arith_res, result;
    logic [DATA_W-1:0]   sum, diff;
    logic                ovf_add, ovf_sub, ovf;
    logic                is_md;
    logic [2*DATA_W-1:0] prod_s, prod_u;
    logic                hilo_we;
    logic [DATA_W-1:0]   hi, lo;
    logic                stallreq;

    assign shamt = rdata1_i[SH_W-1:0];
    assign sum   = rdata1_i + rdata2_i;
    assign diff  = rdata1_i - rdata2_i;

    // Same-sign operands producing a result of the other sign.
    assign ovf_add = (rdata1_i[DATA_W-1] == rdata2_i[DATA_W-1]) &&
                     (sum[DATA_W-1] != rdata1_i[DATA_W-1]);
    assign ovf_sub = (rdata1_i[DATA_W-1] != rdata2_i[DATA_W-1]) &&
                     (diff[DATA_W-1] != rdata1_i[DATA_W-1]);
    assign ovf     = ((aluop_i == ALUOP_ADD) && ovf_add) ||
                     ((aluop_i == ALUOP_SUB) && ovf_sub);

    assign is_md = (aluop_i == ALUOP_MULT) || (aluop_i == ALUOP_MULTU) || is_div_op(aluop_i);

    always_comb begin
        logic_res = '0;
        case (aluop_i)
            ALUOP_AND: logic_res = rdata1_i & rdata2_i;
            ALUOP_OR:  logic_res = rdata1_i | rdata2_i;
            ALUOP_XOR: logic_res = rdata1_i ^ rdata2_i;
            ALUOP_NOR: logic_res = ~(rdata1_i | rdata2_i);
            default:   logic_res = '0;
        endcase
    end

    always_comb begin
        shift_res = '0;
        case (aluop_i)
            ALUOP_SLL: shift_res = rdata2_i << shamt;
            ALUOP_SRL: shift_res = rdata2_i >> shamt;
            ALUOP_SRA: shift_res = $unsigned($signed(rdata2_i) >>> shamt);
            default:   shift_res = '0;
        endcase
    end

    always_comb begin
        arith_res = '0;
        case (aluop_i)
            ALUOP_ADD, ALUOP_ADDU: arith_res = sum;
            ALUOP_SUB, ALUOP_SUBU: arith_res = diff;
            ALUOP_SLT:  arith_res = DATA_W'($signed(rdata1_i) < $signed(rdata2_i));
            ALUOP_SLTU: arith_res = DATA_W'(rdata1_i < rdata2_i);
            default:    arith_res = '0;
        endcase
    end

    always_comb begin
        result = '0;
        case (alusel_i)
            ALUSEL_LOGIC: result = logic_res;
            ALUSEL_SHIFT: result = shift_res;
            ALUSEL_ARITH: result = arith_res;
            ALUSEL_LINK:  result = DATA_W'(laddr_i);
            default:      result = '0;
        endcase
        if (is_md) result = '0;
    end

    // Signed product from sign-extended operands; low 2W bits are exact.
    assign prod_s = {{DATA_W{rdata1_i[DATA_W-1]}}, rdata1_i} *
                    {{DATA_W{rdata2_i[DATA_W-1]}}, rdata2_i};
    assign prod_u = {{DATA_W{1'b0}}, rdata1_i} * {{DATA_W{1'b0}}, rdata2_i};

`ifdef EX_DIV_EN
    logic              div_busy, div_done;
    logic [DATA_W-1:0] div_quo, div_rem;

    ex_div #(.DATA_W(DATA_W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (is_div_op(aluop_i)),
        .signed_op (aluop_i == ALUOP_DIV),
        .flush     (flush_i),
        .hold      (stall_i),
        .dividend  (rdata1_i),
        .divisor   (rdata2_i),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign stallreq = div_busy;
`else
    logic unused_div;
    assign unused_div = ^{clk, flush_i, stall_i};
    assign stallreq   = STALLREQ_DISABLE;
`endif

    always_comb begin
        hilo_we = 1'b0;
        hi      = '0;
        lo      = '0;
        if (aluop_i == ALUOP_MULT) begin
            hilo_we = 1'b1;
            {hi, lo} = prod_s;
        end else if (aluop_i == ALUOP_MULTU) begin
            hilo_we = 1'b1;
            {hi, lo} = prod_u;
        end
`ifdef EX_DIV_EN
        if (div_done) begin
            hilo_we = 1'b1;
            hi      = div_rem;
            lo      = div_quo;
        end
`endif
    end

    assign waddr_o    = rst ? waddr_i : '0;
    assign we_o       = rst & we_i & ~ovf;
    assign wdata_o    = rst ? result : '0;
    assign ovf_o      = rst & ovf;
    assign hilo_we_o  = rst & hilo_we;
    assign hi_o       = rst ? hi : '0;
    assign lo_o       = rst ? lo : '0;
    assign stallreq_o = rst & stallreq;

endmodule

// File: tb/tb_ex_md_unit.sv
module tb_ex_md_unit;
    import ex_md_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i, stall_i;
    aluop_bus_t  aluop_i;
    alusel_bus_t alusel_i;
    logic [31:0] rdata1_i, rdata2_i;
    logic [4:0]  waddr_i;
    logic        we_i;
    logic [31:0] laddr_i;
    logic [4:0]  waddr_o;
    logic        we_o;
    logic [31:0] wdata_o;
    logic        ovf_o, hilo_we_o;
    logic [31:0] hi_o, lo_o;
    logic        stallreq_o;

    int total = 0;
    int bad   = 0;

    ex_md_unit #(.DATA_W(32), .RADDR_W(5), .IADDR_W(32)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .stall_i(stall_i),
        .aluop_i(aluop_i), .alusel_i(alusel_i),
        .rdata1_i(rdata1_i), .rdata2_i(rdata2_i),
        .waddr_i(waddr_i), .we_i(we_i), .laddr_i(laddr_i),
        .waddr_o(waddr_o), .we_o(we_o), .wdata_o(wdata_o), .ovf_o(ovf_o),
        .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic set_op(input aluop_bus_t op, input alusel_bus_t sel,
                          input logic [31:0] a, input logic [31:0] b);
        aluop_i  = op;
        alusel_i = sel;
        rdata1_i = a;
        rdata2_i = b;
    endtask

    task automatic test_reset;
        rst = 1'b0; flush_i = 0; stall_i = 0; we_i = 1'b1; waddr_i = 5'd5;
        laddr_i = 32'h0040_0008;
        set_op(ALUOP_ADD, ALUSEL_ARITH, 32'h7fff_ffff, 32'h1);
        repeat (2) @(posedge clk);
        #2;
        total++;
        if ({stallreq_o, hilo_we_o, hi_o, lo_o, ovf_o, we_o, wdata_o, waddr_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {stallreq_o, hilo_we_o, hi_o, lo_o, ovf_o, we_o, wdata_o, waddr_o});
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_arith;
        we_i = 1'b1; waddr_i = 5'd9;
        set_op(ALUOP_ADD, ALUSEL_ARITH, 32'h7fff_ffff, 32'h1); #1;
        total++;
        if ({ovf_o, we_o} !== 2'b10) begin bad++; $display("FAIL add_ovf got=%b exp=10", {ovf_o, we_o}); end
        total++;
        if (waddr_o !== 5'd9) begin bad++; $display("FAIL waddr got=%0d exp=9", waddr_o); end
        set_op(ALUOP_ADDU, ALUSEL_ARITH, 32'h7fff_ffff, 32'h1); #1;
        total++;
        if ({ovf_o, we_o, wdata_o} !== {2'b01, 32'h8000_0000}) begin
            bad++; $display("FAIL addu got=%b/%h exp=01/80000000", {ovf_o, we_o}, wdata_o);
        end
        set_op(ALUOP_SUB, ALUSEL_ARITH, 32'h8000_0000, 32'h1); #1;
        total++;
        if ({ovf_o, we_o} !== 2'b10) begin bad++; $display("FAIL sub_ovf got=%b exp=10", {ovf_o, we_o}); end
        set_op(ALUOP_SUB, ALUSEL_ARITH, 32'd5, 32'd7); #1;
        total++;
        if ({ovf_o, we_o, wdata_o} !== {2'b01, 32'hffff_fffe}) begin
            bad++; $display("FAIL sub got=%b/%h exp=01/fffffffe", {ovf_o, we_o}, wdata_o);
        end
        set_op(ALUOP_SUBU, ALUSEL_ARITH, 32'h8000_0000, 32'h1); #1;
        total++;
        if ({ovf_o, we_o, wdata_o} !== {2'b01, 32'h7fff_ffff}) begin
            bad++; $display("FAIL subu got=%b/%h exp=01/7fffffff", {ovf_o, we_o}, wdata_o);
        end
        set_op(ALUOP_SLT, ALUSEL_ARITH, 32'hffff_ffff, 32'h1); #1;
        total++;
        if (wdata_o !== 32'h1) begin bad++; $display("FAIL slt got=%h exp=1", wdata_o); end
        set_op(ALUOP_SLTU, ALUSEL_ARITH, 32'hffff_ffff, 32'h1); #1;
        total++;
        if (wdata_o !== 32'h0) begin bad++; $display("FAIL sltu got=%h exp=0", wdata_o); end
    endtask

    task automatic test_logic_shift;
        set_op(ALUOP_AND, ALUSEL_LOGIC, 32'h0000_f0f0, 32'h0000_ff00); #1;
        total++;
        if (wdata_o !== 32'h0000_f000) begin bad++; $display("FAIL and got=%h exp=0000f000", wdata_o); end
        set_op(ALUOP_XOR, ALUSEL_LOGIC, 32'h0000_f0f0, 32'h0000_ff00); #1;
        total++;
        if (wdata_o !== 32'h0000_0ff0) begin bad++; $display("FAIL xor got=%h exp=00000ff0", wdata_o); end
        set_op(ALUOP_NOR, ALUSEL_LOGIC, 32'h0, 32'h0000_0001); #1;
        total++;
        if (wdata_o !== 32'hffff_fffe) begin bad++; $display("FAIL nor got=%h exp=fffffffe", wdata_o); end
        // 0x24 -> only the low 5 bits (4) count as shift amount.
        set_op(ALUOP_SLL, ALUSEL_SHIFT, 32'h24, 32'h1); #1;
        total++;
        if (wdata_o !== 32'h10) begin bad++; $display("FAIL sll got=%h exp=00000010", wdata_o); end
        set_op(ALUOP_SRL, ALUSEL_SHIFT, 32'h4, 32'h8000_0000); #1;
        total++;
        if (wdata_o !== 32'h0800_0000) begin bad++; $display("FAIL srl got=%h exp=08000000", wdata_o); end
        set_op(ALUOP_SRA, ALUSEL_SHIFT, 32'h4, 32'h8000_0000); #1;
        total++;
        if (wdata_o !== 32'hf800_0000) begin bad++; $display("FAIL sra got=%h exp=f8000000", wdata_o); end
        laddr_i = 32'h0040_0008;
        set_op(ALUOP_NOP, ALUSEL_LINK, 32'h0, 32'h0); #1;
        total++;
        if (wdata_o !== 32'h0040_0008) begin bad++; $display("FAIL link got=%h exp=00400008", wdata_o); end
    endtask

    task automatic test_mult;
        set_op(ALUOP_MULT, ALUSEL_HILO, 32'hffff_ffff, 32'h2); #1;
        total++;
        if ({hilo_we_o, stallreq_o, hi_o, lo_o} !== {2'b10, 32'hffff_ffff, 32'hffff_fffe}) begin
            bad++; $display("FAIL mult got=%b %h %h exp=10 ffffffff fffffffe",
                            {hilo_we_o, stallreq_o}, hi_o, lo_o);
        end
        total++;
        if ({we_o, wdata_o} !== {1'b1, 32'h0}) begin
            bad++; $display("FAIL mult_wdata got=%b/%h exp=1/0", we_o, wdata_o);
        end
        set_op(ALUOP_MULTU, ALUSEL_HILO, 32'hffff_ffff, 32'h2); #1;
        total++;
        if ({hilo_we_o, hi_o, lo_o} !== {1'b1, 32'h1, 32'hffff_fffe}) begin
            bad++; $display("FAIL multu got=%b %h %h exp=1 00000001 fffffffe", hilo_we_o, hi_o, lo_o);
        end
        set_op(ALUOP_NOP, ALUSEL_NOP, 32'h0, 32'h0); #1;
        total++;
        if (hilo_we_o !== 1'b0) begin bad++; $display("FAIL nop_hilo got=%b exp=0", hilo_we_o); end
    endtask

`ifdef EX_DIV_EN
    // Issue a divide right after a posedge and count stall cycles up to DONE.
    task automatic run_div(input aluop_bus_t op, input logic [31:0] a, input logic [31:0] b,
                           output int n);
        set_op(op, ALUSEL_HILO, a, b);
        #1;
        n = 0;
        while (stallreq_o === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #2;
        end
    endtask

    task automatic test_div_signed;
        int n;
        run_div(ALUOP_DIV, 32'hffff_fff9, 32'd2, n);
        total++;
        if (n !== 33) begin bad++; $display("FAIL div_stall_cycles got=%0d exp=33", n); end
        total++;
        if ({hilo_we_o, stallreq_o, hi_o, lo_o} !== {2'b10, 32'hffff_ffff, 32'hffff_fffd}) begin
            bad++; $display("FAIL div_neg7_2 got=%b %h %h exp=10 ffffffff fffffffd",
                            {hilo_we_o, stallreq_o}, hi_o, lo_o);
        end
        set_op(ALUOP_NOP, ALUSEL_NOP, 32'h0, 32'h0);
        @(posedge clk); #1;
        total++;
        if (hilo_we_o !== 1'b0) begin bad++; $display("FAIL div_one_write got=%b exp=0", hilo_we_o); end
    endtask

    task automatic test_div_zero;
        int n;
        run_div(ALUOP_DIVU, 32'd100, 32'd0, n);
        total++;
        if (n !== 1) begin bad++; $display("FAIL divzero_stall got=%0d exp=1", n); end
        total++;
        if ({hilo_we_o, hi_o, lo_o} !== {1'b1, 32'd100, 32'hffff_ffff}) begin
            bad++; $display("FAIL divzero got=%b %h %h exp=1 00000064 ffffffff", hilo_we_o, hi_o, lo_o);
        end
        set_op(ALUOP_NOP, ALUSEL_NOP, 32'h0, 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic test_div_minneg;
        int n;
        run_div(ALUOP_DIV, 32'h8000_0000, 32'hffff_ffff, n);
        total++;
        if ({hilo_we_o, hi_o, lo_o} !== {1'b1, 32'h0, 32'h8000_0000}) begin
            bad++; $display("FAIL div_minneg got=%b %h %h exp=1 00000000 80000000", hilo_we_o, hi_o, lo_o);
        end
        set_op(ALUOP_NOP, ALUSEL_NOP, 32'h0, 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic test_flush;
        int hits;
        set_op(ALUOP_DIVU, ALUSEL_HILO, 32'd10, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        flush_i = 1'b1; #1;
        total++;
        if ({stallreq_o, hilo_we_o} !== 2'b00) begin
            bad++; $display("FAIL flush_now got=%b exp=00", {stallreq_o, hilo_we_o});
        end
        set_op(ALUOP_NOP, ALUSEL_NOP, 32'h0, 32'h0);
        @(posedge clk); #1;
        flush_i = 1'b0; #1;
        total++;
        if (stallreq_o !== 1'b0) begin bad++; $display("FAIL flush_next got=%b exp=0", stallreq_o); end
        hits = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (hilo_we_o !== 1'b0 || stallreq_o !== 1'b0) hits++;
        end
        total++;
        if (hits !== 0) begin bad++; $display("FAIL flush_no_write got=%0d exp=0", hits); end
    endtask

    task automatic test_rst_abort;
        int hits;
        we_i = 1'b1; waddr_i = 5'd3;
        set_op(ALUOP_DIVU, ALUSEL_HILO, 32'd10, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0; #1;
        total++;
        if ({stallreq_o, hilo_we_o, hi_o, lo_o, ovf_o, we_o, wdata_o, waddr_o} !== '0) begin
            bad++; $display("FAIL rst_abort_outputs got=%h exp=0",
                            {stallreq_o, hilo_we_o, hi_o, lo_o, ovf_o, we_o, wdata_o, waddr_o});
        end
        set_op(ALUOP_NOP, ALUSEL_NOP, 32'h0, 32'h0);
        @(negedge clk) rst = 1'b1;
        hits = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (hilo_we_o !== 1'b0 || stallreq_o !== 1'b0) hits++;
        end
        total++;
        if (hits !== 0) begin bad++; $display("FAIL rst_no_write got=%0d exp=0", hits); end
    endtask

    task automatic test_hold;
        int n;
        run_div(ALUOP_DIVU, 32'd10, 32'd3, n);
        total++;
        if (n !== 33) begin bad++; $display("FAIL hold_stall got=%0d exp=33", n); end
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if ({hilo_we_o, stallreq_o, hi_o, lo_o} !== {2'b10, 32'd1, 32'd3}) begin
                bad++; $display("FAIL hold_cycle%0d got=%b %h %h exp=10 00000001 00000003",
                                k, {hilo_we_o, stallreq_o}, hi_o, lo_o);
            end
            @(posedge clk); #1;
        end
        stall_i = 1'b0; #1;
        total++;
        if ({hilo_we_o, lo_o} !== {1'b1, 32'd3}) begin
            bad++; $display("FAIL hold_release got=%b %h exp=1 00000003", hilo_we_o, lo_o);
        end
        set_op(ALUOP_NOP, ALUSEL_NOP, 32'h0, 32'h0);
        @(posedge clk); #1;
        total++;
        if (hilo_we_o !== 1'b0) begin bad++; $display("FAIL hold_exit got=%b exp=0", hilo_we_o); end
    endtask

    task automatic test_back_to_back;
        int n;
        run_div(ALUOP_DIVU, 32'd20, 32'd6, n);
        total++;
        if ({hilo_we_o, hi_o, lo_o} !== {1'b1, 32'd2, 32'd3}) begin
            bad++; $display("FAIL b2b_first got=%b %h %h exp=1 00000002 00000003", hilo_we_o, hi_o, lo_o);
        end
        set_op(ALUOP_DIVU, ALUSEL_HILO, 32'd9, 32'd4);
        @(posedge clk);
        run_div(ALUOP_DIVU, 32'd9, 32'd4, n);
        total++;
        if (n !== 33) begin bad++; $display("FAIL b2b_stall got=%0d exp=33", n); end
        total++;
        if ({hilo_we_o, hi_o, lo_o} !== {1'b1, 32'd1, 32'd2}) begin
            bad++; $display("FAIL b2b_second got=%b %h %h exp=1 00000001 00000002", hilo_we_o, hi_o, lo_o);
        end
        set_op(ALUOP_NOP, ALUSEL_NOP, 32'h0, 32'h0);
        @(posedge clk); #1;
    endtask
`else
    task automatic test_div_disabled;
        set_op(ALUOP_DIV, ALUSEL_HILO, 32'd7, 32'd2); #1;
        total++;
        if ({hilo_we_o, stallreq_o, hi_o, lo_o} !== '0) begin
            bad++; $display("FAIL div_disabled got=%b %h %h exp=00 0 0",
                            {hilo_we_o, stallreq_o}, hi_o, lo_o);
        end
        @(posedge clk); #1;
        set_op(ALUOP_DIVU, ALUSEL_HILO, 32'd100, 32'd0); #1;
        total++;
        if ({hilo_we_o, stallreq_o, hi_o, lo_o} !== '0) begin
            bad++; $display("FAIL divu_disabled got=%b %h %h exp=00 0 0",
                            {hilo_we_o, stallreq_o}, hi_o, lo_o);
        end
        set_op(ALUOP_NOP, ALUSEL_NOP, 32'h0, 32'h0);
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_arith();
        test_logic_shift();
        test_mult();
`ifdef EX_DIV_EN
        test_div_signed();
        test_div_zero();
        test_div_minneg();
        test_flush();
        test_rst_abort();
        test_hold();
        test_back_to_back();
`else
        test_div_disabled();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
